// File: rtl/rc_arbiter_if.sv
// Handshake bundle between ingress buffers, the route-compute arbiter and route compute.
// master is the arbiter side; slave is the environment (buffers + route compute).
interface rc_arbiter_if #(
  parameter int unsigned NUM_INPORTS = 5,
  parameter int unsigned META_W      = 32,
  parameter int unsigned DEST_W      = 8
);
  localparam int unsigned PW = $clog2(NUM_INPORTS) + ((NUM_INPORTS == 1) ? 1 : 0);

  logic [NUM_INPORTS-1:0]             port_enable;
  logic [NUM_INPORTS-1:0]             req;
  logic [NUM_INPORTS-1:0][META_W-1:0] req_metadata;
  logic [NUM_INPORTS-1:0][DEST_W-1:0] req_dest;
  logic [NUM_INPORTS-1:0]             grant;
  logic                               rc_ready;
  logic                               rc_valid;
  logic [META_W-1:0]                  rc_metadata;
  logic [DEST_W-1:0]                  rc_dest;
  logic [PW-1:0]                      rc_ingress_port;

  modport master (
    input  port_enable, req, req_metadata, req_dest, rc_ready,
    output grant, rc_valid, rc_metadata, rc_dest, rc_ingress_port
  );

  modport slave (
    output port_enable, req, req_metadata, req_dest, rc_ready,
    input  grant, rc_valid, rc_metadata, rc_dest, rc_ingress_port
  );
endinterface

// File: rtl/rc_arbiter.sv
// Round-robin arbiter with starvation override that feeds the shared route-compute stage
// from the ingress head-flit requests through a registered, backpressure-holding bundle.
module rc_arbiter #(
  parameter int unsigned NUM_INPORTS = 5,
  parameter int unsigned META_W      = 32,
  parameter int unsigned DEST_W      = 8,
  parameter int unsigned MAX_WAIT    = 15
) (
  input logic          clk,
  input logic          n_rst,
  rc_arbiter_if.master bus
);
  localparam int unsigned PW = $clog2(NUM_INPORTS) + ((NUM_INPORTS == 1) ? 1 : 0);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [PW-1:0] LastIdx = PW'(NUM_INPORTS - 1);
  localparam logic [WW-1:0] WaitMax = WW'(MAX_WAIT);

  logic [NUM_INPORTS-1:0] eligible;
  logic [NUM_INPORTS-1:0] starved;
  logic [NUM_INPORTS-1:0] cand;
  logic [NUM_INPORTS-1:0] grant_d;
  logic                   accept;
  logic                   found;
  logic [PW-1:0]          win;

  logic                         rc_valid_q;
  logic [META_W-1:0]            rc_meta_q;
  logic [DEST_W-1:0]            rc_dest_q;
  logic [PW-1:0]                rc_port_q;
  logic [PW-1:0]                rr_ptr_q;
  logic [NUM_INPORTS-1:0][WW-1:0] wait_q;

  always_comb begin
    int idx;
    eligible = bus.req & bus.port_enable;
    accept   = !rc_valid_q || bus.rc_ready;
    for (int i = 0; i < int'(NUM_INPORTS); i++) begin
      starved[i] = eligible[i] && (wait_q[i] == WaitMax);
    end
    // Starved requesters shut out everyone else until they are served.
    cand  = (|starved) ? starved : eligible;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NUM_INPORTS); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(NUM_INPORTS)) idx = idx - int'(NUM_INPORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    grant_d = '0;
    if (n_rst && accept && found) grant_d[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rc_valid_q <= 1'b0;
      rc_meta_q  <= '0;
      rc_dest_q  <= '0;
      rc_port_q  <= '0;
      rr_ptr_q   <= '0;
      wait_q     <= '0;
    end else begin
      if (accept) begin
        if (found) begin
          rc_valid_q <= 1'b1;
          rc_meta_q  <= bus.req_metadata[win];
          rc_dest_q  <= bus.req_dest[win];
          rc_port_q  <= win;
          rr_ptr_q   <= (win == LastIdx) ? '0 : win + 1'b1;
        end else begin
          rc_valid_q <= 1'b0;
        end
      end
      // Stall cycles count as waiting; a granted or ineligible port restarts from zero.
      for (int i = 0; i < int'(NUM_INPORTS); i++) begin
        if (!eligible[i] || grant_d[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != WaitMax) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  assign bus.grant           = grant_d;
  assign bus.rc_valid        = rc_valid_q;
  assign bus.rc_metadata     = rc_meta_q;
  assign bus.rc_dest         = rc_dest_q;
  assign bus.rc_ingress_port = rc_port_q;
endmodule

// File: tb/tb_rc_arbiter.sv
// Directed bench for rc_arbiter: rotation, backpressure, reset, masking, starvation and the
// single-port build, each with hand-computed expectations.
module tb_rc_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst_a, n_rst_s, n_rst_1;
  int checks = 0;
  int errors = 0;

  rc_arbiter_if #(.NUM_INPORTS(5), .META_W(32), .DEST_W(8)) bus_a ();
  rc_arbiter_if #(.NUM_INPORTS(5), .META_W(32), .DEST_W(8)) bus_s ();
  rc_arbiter_if #(.NUM_INPORTS(1), .META_W(32), .DEST_W(8)) bus_1 ();

  rc_arbiter #(.NUM_INPORTS(5), .META_W(32), .DEST_W(8), .MAX_WAIT(15)) dut_a (
    .clk(clk), .n_rst(n_rst_a), .bus(bus_a)
  );
  rc_arbiter #(.NUM_INPORTS(5), .META_W(32), .DEST_W(8), .MAX_WAIT(3)) dut_s (
    .clk(clk), .n_rst(n_rst_s), .bus(bus_s)
  );
  rc_arbiter #(.NUM_INPORTS(1), .META_W(32), .DEST_W(8), .MAX_WAIT(15)) dut_1 (
    .clk(clk), .n_rst(n_rst_1), .bus(bus_1)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst_a = 1'b0; n_rst_s = 1'b0; n_rst_1 = 1'b0;
    bus_a.req = 5'b11111; bus_a.port_enable = 5'b11111; bus_a.rc_ready = 1'b1;
    mid();
    checks++;
    if (bus_a.grant !== 5'b00000) begin
      errors++; $display("FAIL reset_grant_forced: got %b want 00000", bus_a.grant);
    end
    next_cycle();
    mid();
    checks++;
    if (bus_a.rc_valid !== 1'b0 || bus_a.rc_ingress_port !== 3'd0 || bus_a.rc_dest !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid %b port %0d dest %h want 0 0 00",
               bus_a.rc_valid, bus_a.rc_ingress_port, bus_a.rc_dest);
    end
    checks++;
    if (bus_s.rc_valid !== 1'b0 || bus_1.rc_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid_other: got %b %b want 0 0", bus_s.rc_valid, bus_1.rc_valid);
    end
    next_cycle();
    n_rst_a = 1'b1; n_rst_s = 1'b1; n_rst_1 = 1'b1;
    bus_a.req = 5'b00000;
    next_cycle();
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 2, 4, 0, 2, 4};
    logic [4:0] exp_g;
    bus_a.req = 5'b10101;
    for (int c = 0; c < 6; c++) begin
      mid();
      exp_g = 5'b00001 << seq[c];
      checks++;
      if (bus_a.grant !== exp_g) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, bus_a.grant, exp_g);
      end
      checks++;
      if (c == 0) begin
        if (bus_a.rc_valid !== 1'b0) begin
          errors++; $display("FAIL rr_first_valid: got %b want 0", bus_a.rc_valid);
        end
      end else if (bus_a.rc_valid !== 1'b1 || bus_a.rc_ingress_port !== 3'(seq[c-1]) ||
                   bus_a.rc_metadata !== 32'hA000_0000 + 32'(seq[c-1])) begin
        errors++;
        $display("FAIL rr_bundle[%0d]: valid %b port %0d meta %h want 1 %0d %h", c,
                 bus_a.rc_valid, bus_a.rc_ingress_port, bus_a.rc_metadata, seq[c-1],
                 32'hA000_0000 + 32'(seq[c-1]));
      end
      next_cycle();
    end
    bus_a.req = 5'b00000;
    mid();
    checks++;
    if (bus_a.grant !== 5'b00000 || bus_a.rc_valid !== 1'b1 || bus_a.rc_ingress_port !== 3'd4) begin
      errors++;
      $display("FAIL rr_idle: grant %b valid %b port %0d want 00000 1 4",
               bus_a.grant, bus_a.rc_valid, bus_a.rc_ingress_port);
    end
    next_cycle();
    mid();
    checks++;
    if (bus_a.rc_valid !== 1'b0) begin
      errors++; $display("FAIL rr_drain_valid: got %b want 0", bus_a.rc_valid);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    bus_a.req = 5'b00010; bus_a.rc_ready = 1'b1;
    mid();
    checks++;
    if (bus_a.grant !== 5'b00010) begin
      errors++; $display("FAIL bp_first_grant: got %b want 00010", bus_a.grant);
    end
    next_cycle();
    bus_a.req = 5'b11111; bus_a.rc_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      mid();
      checks++;
      if (bus_a.grant !== 5'b00000 || bus_a.rc_valid !== 1'b1 || bus_a.rc_ingress_port !== 3'd1 ||
          bus_a.rc_metadata !== 32'hA000_0001 || bus_a.rc_dest !== 8'h11) begin
        errors++;
        $display("FAIL bp_hold[t+%0d]: grant %b valid %b port %0d meta %h dest %h want 00000 1 1 a0000001 11",
                 c, bus_a.grant, bus_a.rc_valid, bus_a.rc_ingress_port, bus_a.rc_metadata,
                 bus_a.rc_dest);
      end
      next_cycle();
    end
    bus_a.rc_ready = 1'b1;
    mid();
    checks++;
    if (bus_a.grant !== 5'b00100 || bus_a.rc_ingress_port !== 3'd1) begin
      errors++;
      $display("FAIL bp_refill: grant %b port %0d want 00100 1", bus_a.grant, bus_a.rc_ingress_port);
    end
    next_cycle();
    bus_a.req = 5'b00000;
    mid();
    checks++;
    if (bus_a.rc_valid !== 1'b1 || bus_a.rc_ingress_port !== 3'd2 || bus_a.rc_dest !== 8'h12) begin
      errors++;
      $display("FAIL bp_next_bundle: valid %b port %0d dest %h want 1 2 12",
               bus_a.rc_valid, bus_a.rc_ingress_port, bus_a.rc_dest);
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus_a.req = 5'b10000;
    mid();
    checks++;
    if (bus_a.grant !== 5'b10000) begin
      errors++; $display("FAIL rst_mid_grant4: got %b want 10000", bus_a.grant);
    end
    next_cycle();
    n_rst_a = 1'b0; bus_a.req = 5'b11111;
    mid();
    checks++;
    if (bus_a.grant !== 5'b00000) begin
      errors++; $display("FAIL rst_mid_grant_forced: got %b want 00000", bus_a.grant);
    end
    next_cycle();
    n_rst_a = 1'b1;
    mid();
    checks++;
    if (bus_a.rc_valid !== 1'b0 || bus_a.grant !== 5'b00001) begin
      errors++;
      $display("FAIL rst_mid_release: valid %b grant %b want 0 00001", bus_a.rc_valid, bus_a.grant);
    end
    next_cycle();
    bus_a.req = 5'b00000;
    mid();
    checks++;
    if (bus_a.rc_valid !== 1'b1 || bus_a.rc_ingress_port !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_bundle: valid %b port %0d want 1 0", bus_a.rc_valid, bus_a.rc_ingress_port);
    end
    next_cycle();
  endtask

  task automatic test_port_mask();
    int seq [8] = '{1, 3, 4, 0, 1, 3, 4, 0};
    logic [4:0] exp_g;
    bus_a.req = 5'b11111; bus_a.port_enable = 5'b11011;
    for (int c = 0; c < 8; c++) begin
      mid();
      exp_g = 5'b00001 << seq[c];
      checks++;
      if (bus_a.grant !== exp_g) begin
        errors++; $display("FAIL mask_grant[%0d]: got %b want %b", c, bus_a.grant, exp_g);
      end
      next_cycle();
    end
    bus_a.req = 5'b00000; bus_a.port_enable = 5'b11111;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_starvation();
    logic ready_pat [3] = '{1'b1, 1'b0, 1'b1};
    // Port 3 requests but is masked: nothing may be granted.
    bus_s.port_enable = 5'b10111; bus_s.req = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      bus_s.rc_ready = ready_pat[c];
      mid();
      checks++;
      if (bus_s.grant !== 5'b00000 || bus_s.rc_valid !== 1'b0) begin
        errors++;
        $display("FAIL starve_masked[%0d]: grant %b valid %b want 00000 0", c, bus_s.grant,
                 bus_s.rc_valid);
      end
      next_cycle();
    end
    bus_s.port_enable = 5'b11111; bus_s.req = 5'b01001; bus_s.rc_ready = 1'b1;
    mid();
    checks++;
    if (bus_s.grant !== 5'b00001) begin
      errors++; $display("FAIL starve_load: got %b want 00001", bus_s.grant);
    end
    next_cycle();
    bus_s.req = 5'b01000; bus_s.rc_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mid();
      checks++;
      if (bus_s.grant !== 5'b00000) begin
        errors++; $display("FAIL starve_stall[%0d]: got %b want 00000", c, bus_s.grant);
      end
      next_cycle();
    end
    bus_s.req = 5'b01111; bus_s.rc_ready = 1'b1;
    mid();
    checks++;
    if (dut_s.wait_q[3] !== 2'd3) begin
      errors++; $display("FAIL starve_wait_sat: got %0d want 3", dut_s.wait_q[3]);
    end
    checks++;
    if (bus_s.grant !== 5'b01000 || bus_s.rc_ingress_port !== 3'd0) begin
      errors++;
      $display("FAIL starve_override: grant %b port %0d want 01000 0", bus_s.grant,
               bus_s.rc_ingress_port);
    end
    next_cycle();
    bus_s.req = 5'b00111;
    mid();
    checks++;
    if (bus_s.grant !== 5'b00001 || bus_s.rc_ingress_port !== 3'd3 || bus_s.rc_dest !== 8'h13) begin
      errors++;
      $display("FAIL starve_after: grant %b port %0d dest %h want 00001 3 13", bus_s.grant,
               bus_s.rc_ingress_port, bus_s.rc_dest);
    end
    next_cycle();
    bus_s.req = 5'b00000;
    next_cycle();
  endtask

  task automatic test_single_port();
    bus_1.port_enable = 1'b1; bus_1.req = 1'b1; bus_1.rc_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (bus_1.grant !== 1'b1) begin
        errors++; $display("FAIL single_grant[%0d]: got %b want 1", c, bus_1.grant);
      end
      if (c > 0) begin
        checks++;
        if (bus_1.rc_valid !== 1'b1 || bus_1.rc_ingress_port !== 1'b0 ||
            bus_1.rc_metadata !== 32'hB000_0000) begin
          errors++;
          $display("FAIL single_bundle[%0d]: valid %b port %0d meta %h want 1 0 b0000000", c,
                   bus_1.rc_valid, bus_1.rc_ingress_port, bus_1.rc_metadata);
        end
      end
      next_cycle();
    end
    bus_1.req = 1'b0;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req = '0; bus_a.port_enable = '0; bus_a.rc_ready = 1'b0;
    bus_s.req = '0; bus_s.port_enable = '0; bus_s.rc_ready = 1'b0;
    bus_1.req = '0; bus_1.port_enable = '0; bus_1.rc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_a.req_metadata[i] = 32'hA000_0000 + 32'(i);
      bus_a.req_dest[i]     = 8'h10 + 8'(i);
      bus_s.req_metadata[i] = 32'hC000_0000 + 32'(i);
      bus_s.req_dest[i]     = 8'h10 + 8'(i);
    end
    bus_1.req_metadata[0] = 32'hB000_0000;
    bus_1.req_dest[0]     = 8'h20;
    n_rst_a = 1'b0; n_rst_s = 1'b0; n_rst_1 = 1'b0;
    next_cycle();

    test_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_port_mask();
    test_starvation();
    test_single_port();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
